// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: serial line, CPU pop/clear strobes and receive status of the RX FIFO.
interface uart_rx_fifo_if #(parameter int FIFO_AW = 4);
  logic               rxd;
  logic               rd_strb;
  logic               clr_err;
  logic [7:0]         rd_data;
  logic               rx_valid;
  logic [FIFO_AW:0]   rx_count;
  logic               overrun;
  logic               frame_err;
  logic               parity_err;
  modport master(output rxd, rd_strb, clr_err,
                 input rd_data, rx_valid, rx_count, overrun, frame_err, parity_err);
  modport slave(input rxd, rd_strb, clr_err,
                output rd_data, rx_valid, rx_count, overrun, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a byte FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int FIFO_AW     = 4
) (
  input logic clk,
  input logic resetn,
  uart_rx_fifo_if.slave bus
);
  localparam int CPB   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW    = $clog2(CPB);
  localparam int DEPTH = 2 ** FIFO_AW;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam state_t AFTER_DATA = PARITY;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_n;
  logic [2:0] sync;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic [7:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wp, rp;
  logic [FIFO_AW:0] count;
  logic overrun, frame_err, par_bad;
  logic push, shift, set_fe, set_pe, pop, wr, ovf;
  // sync[1] is the resynchronised line, sync[2] its previous value for edge detection
  wire sample = sync[1];
  wire fall   = sync[2] & ~sync[1];
  wire tick   = cnt == '0;
  always_ff @(posedge clk)
    state <= !resetn ? IDLE : state_n;
  always_comb begin
    state_n = state;
    cnt_n   = tick ? CW'(CPB - 1) : cnt - 1'b1;
    push    = 1'b0;
    shift   = 1'b0;
    set_fe  = 1'b0;
    set_pe  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = CW'(CPB / 2 - 1);
        state_n = fall ? START : IDLE;
      end
      START: state_n = tick ? (sample ? IDLE : DATA) : START;
      DATA: begin
        shift   = tick;
        state_n = tick && idx == 3'd7 ? AFTER_DATA : DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        set_pe  = tick & (^{shreg, sample});
        state_n = tick ? STOP : PARITY;
      end
`endif
      STOP: begin
        push    = tick & sample & ~par_bad;
        set_fe  = tick & ~sample;
        state_n = tick ? IDLE : STOP;
      end
      default: state_n = IDLE;
    endcase
  end
  assign pop = bus.rd_strb & (count != '0);
  assign wr  = push & ((count != DEPTH[FIFO_AW:0]) | pop);
  assign ovf = push & (count == DEPTH[FIFO_AW:0]) & ~pop;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync      <= '1;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[1:0], bus.rxd};
      cnt       <= cnt_n;
      idx       <= state == DATA ? idx + 3'(tick) : '0;
      shreg     <= shift ? {sample, shreg[7:1]} : shreg;
      wp        <= wp + FIFO_AW'(wr);
      rp        <= rp + FIFO_AW'(pop);
      count     <= count + (FIFO_AW + 1)'(wr) - (FIFO_AW + 1)'(pop);
      overrun   <= ovf | (overrun & ~bus.clr_err);
      frame_err <= set_fe | (frame_err & ~bus.clr_err);
    end
  end
  always_ff @(posedge clk)
    if (resetn && wr) mem[wp] <= shreg;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad    <= state == PARITY && tick ? ^{shreg, sample} : par_bad;
      parity_err <= set_pe | (parity_err & ~bus.clr_err);
    end
  end
  assign bus.parity_err = parity_err;
`else
  assign par_bad        = 1'b0;
  assign bus.parity_err = 1'b0;
`endif
  assign bus.rd_data   = mem[rp];
  assign bus.rx_valid  = count != '0;
  assign bus.rx_count  = count;
  assign bus.overrun   = overrun;
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frame table plus latency, glitch, overrun, full push/pop and reset sequences.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int pass_cnt = 0;
  int total = 0;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 171;
`else
  localparam int LAT = 155;
`endif
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       pbad;
    logic       push;
    logic       ferr;
    logic       perr;
  } vec_t;
  vec_t vecs[$];
  uart_rx_fifo_if #(.FIFO_AW(2)) bus();
  uart_rx_fifo #(.CLK_FREQ_HZ(16), .BAUD_RATE(1), .FIFO_AW(2)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic pbad);
    bus.rxd = 1'b0;
    cyc(16);
    for (int i = 0; i < 8; i++) begin
      bus.rxd = b[i];
      cyc(16);
    end
`ifdef UART_RX_PARITY_EN
    bus.rxd = (^b) ^ pbad;
    cyc(16);
`else
    if (pbad) $display("note: parity flip ignored in 8N1 build");
`endif
    bus.rxd = stop;
    cyc(16);
    bus.rxd = 1'b1;
    cyc(4);
  endtask
  task automatic pop_chk(input string name, input logic [7:0] exp);
    chk(name, bus.rd_data, exp);
    bus.rd_strb = 1'b1;
    cyc(1);
    bus.rd_strb = 1'b0;
  endtask
  task automatic clr;
    bus.clr_err = 1'b1;
    cyc(1);
    bus.clr_err = 1'b0;
  endtask
  task automatic chk_idle(input string name);
    chk({name, " valid"}, bus.rx_valid, 0);
    chk({name, " count"}, bus.rx_count, 0);
    chk({name, " overrun"}, bus.overrun, 0);
    chk({name, " frame_err"}, bus.frame_err, 0);
    chk({name, " parity_err"}, bus.parity_err, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs.push_back('{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
`endif
    bus.rxd = 1'b1;
    bus.rd_strb = 1'b0;
    bus.clr_err = 1'b0;
    cyc(3);
    chk_idle("reset");
    resetn = 1'b1;
    cyc(2);
    fork
      send(8'hA5, 1'b1, 1'b0);
      begin
        cyc(LAT - 1);
        chk("latency early valid", bus.rx_valid, 0);
        cyc(1);
        chk("latency valid", bus.rx_valid, 1);
        chk("latency data", bus.rd_data, 8'hA5);
        chk("latency count", bus.rx_count, 1);
      end
    join
    pop_chk("a5 pop", 8'hA5);
    chk("a5 popped valid", bus.rx_valid, 0);
    chk("a5 popped count", bus.rx_count, 0);
    bus.rxd = 1'b0;
    cyc(4);
    bus.rxd = 1'b1;
    cyc(24);
    chk_idle("glitch");
    foreach (vecs[i]) begin
      send(vecs[i].data, vecs[i].stop, vecs[i].pbad);
      chk($sformatf("vec%0d valid", i), bus.rx_valid, vecs[i].push);
      chk($sformatf("vec%0d count", i), bus.rx_count, vecs[i].push ? 1 : 0);
      chk($sformatf("vec%0d frame_err", i), bus.frame_err, vecs[i].ferr);
      chk($sformatf("vec%0d parity_err", i), bus.parity_err, vecs[i].perr);
      if (vecs[i].push) pop_chk($sformatf("vec%0d data", i), vecs[i].data);
      clr;
      chk($sformatf("vec%0d cleared frame_err", i), bus.frame_err, 0);
      chk($sformatf("vec%0d cleared parity_err", i), bus.parity_err, 0);
    end
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b0);
    chk("ovf count", bus.rx_count, 4);
    chk("ovf flag", bus.overrun, 1);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovf pop%0d", i), 8'(i));
    chk("ovf drained valid", bus.rx_valid, 0);
    chk("ovf still set", bus.overrun, 1);
    clr;
    chk("ovf cleared", bus.overrun, 0);
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    send(8'h44, 1'b1, 1'b0);
    chk("full count", bus.rx_count, 4);
    fork
      send(8'h77, 1'b1, 1'b0);
      begin
        cyc(LAT - 1);
        bus.rd_strb = 1'b1;
        cyc(1);
        bus.rd_strb = 1'b0;
        chk("full pushpop count", bus.rx_count, 4);
        chk("full pushpop overrun", bus.overrun, 0);
      end
    join
    pop_chk("full pop 22", 8'h22);
    pop_chk("full pop 33", 8'h33);
    pop_chk("full pop 44", 8'h44);
    pop_chk("full pop 77", 8'h77);
    chk("full drained valid", bus.rx_valid, 0);
    bus.rd_strb = 1'b1;
    cyc(1);
    bus.rd_strb = 1'b0;
    chk("empty pop count", bus.rx_count, 0);
    chk("empty pop valid", bus.rx_valid, 0);
    send(8'h12, 1'b1, 1'b0);
    send(8'h34, 1'b0, 1'b1);
    chk("pre-reset count", bus.rx_count, 1);
    chk("pre-reset frame_err", bus.frame_err, 1);
    fork
      send(8'hF8, 1'b1, 1'b0);
      begin
        cyc(20);
        resetn = 1'b0;
        cyc(50);
        chk_idle("midbyte reset");
        resetn = 1'b1;
      end
    join
    chk_idle("after abandoned byte");
    send(8'h5A, 1'b1, 1'b0);
    chk("post-reset valid", bus.rx_valid, 1);
    chk("post-reset count", bus.rx_count, 1);
    chk("post-reset frame_err", bus.frame_err, 0);
    pop_chk("post-reset data", 8'h5A);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Memory-mapped UART receiver for the SOC IO page. It is the receive-side counterpart of the existing UART emitter.
- Samples the RXD pin, deframes 8N1 characters and buffers them in a small FIFO.
- The SOC IO read mux pops bytes from the FIFO when the CPU reads the RX data word.
- Status (non-empty, fill level, sticky error flags) is exported for the UART control word.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD_RATE, 1000000, line rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer division); it must be >= 4.
- FIFO_AW, 4, FIFO address width. Depth = 2**FIFO_AW entries of 8 bits.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- rxd  in  1  asynchronous serial input; idles high
- rd_strb  in  1  pop request; one byte popped per cycle asserted
- clr_err  in  1  clears the sticky error flags
- rd_data  out  8  byte at FIFO head; valid when rx_valid=1
- rx_valid  out  1  FIFO not empty
- rx_count  out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW
- overrun  out  1  sticky: a received byte was dropped because the FIFO was full
- frame_err  out  1  sticky: a stop bit was sampled as 0
- parity_err  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset is synchronous active-low, clock clk. While resetn=0:
  - FSM goes to IDLE; FIFO pointers and count go to 0.
  - rx_valid=0, rx_count=0, overrun=frame_err=parity_err=0.
  - The synchroniser flops load 1.
  - rd_data is don't-care while empty.
- A reset asserted mid-character abandons the character. After reset the receiver re-arms on the next falling edge.
- Input: 2-flop synchroniser on rxd, plus one extra flop for edge detection.
- FSM states: IDLE, START, DATA, STOP, plus PARITY when the option is enabled. A single down-counter paces all bit timing.
  - IDLE: a synchronised 1->0 transition loads counter=CLKS_PER_BIT/2-1 and moves to START.
  - START: when counter=0, sample the line.
    - 0: go to DATA, counter=CLKS_PER_BIT-1, bit index=0.
    - 1: glitch, return to IDLE with no flag.
  - DATA: when counter=0, shift the sample into shreg LSB-first (shreg <= {bit, shreg[7:1]}) and reload counter.
    - After the 8th bit, go to STOP (or PARITY when enabled).
  - STOP: when counter=0, sample the line, then return to IDLE.
    - 1: push shreg.
    - 0: set frame_err and discard the byte.
- Push timing: the pushed byte appears at rd_data with rx_valid=1 on the cycle after the stop mid-sample edge.
- Total latency from the start-bit falling edge at the pin to rx_valid is 2 sync cycles + 9.5 bit times (10.5 with parity) + 1 cycle.
- FIFO:
  - Circular buffer; rd_data = mem[rd_ptr] (combinational read of a registered array).
  - Pointers wrap modulo 2**FIFO_AW.
  - Pop with count=0 is ignored; rx_count stays 0.
  - Push with count=DEPTH and no pop in the same cycle: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle:
    - Both execute and count is unchanged.
    - When full, the push is accepted (no overrun).
    - When empty, only the push executes and count becomes 1.
- Sticky flags:
  - clr_err=1 clears all three flags.
  - If a set event and clr_err occur in the same cycle, the set wins.
- Receiver restart: after a frame error with the line held low, no new start is detected until the line returns high and falls again. This follows from edge detection.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the 8 data bits and is sampled in state PARITY at mid-bit.
  - If the XOR of the 8 data bits and the parity bit is 1, set parity_err. The byte is still checked for stop, but it is never pushed.
- Undefined:
  - 8N1 only; no PARITY state.
  - parity_err is tied to 0.

Test Plan:
Bench uses CLK_FREQ_HZ=16, BAUD_RATE=1 (CLKS_PER_BIT=16), FIFO_AW=2.
1. Send 0xA5 8N1 -> rx_valid rises 2+152+1 cycles after the start edge, rd_data=0xA5, rx_count=1. Pulse rd_strb -> rx_valid=0, rx_count=0.
2. Low pulse of 4 cycles on idle rxd -> FSM returns to IDLE, no push, no flags. A following 0x3C is received correctly.
3. Send 0x01,0x02,0x03,0x04,0x05 with no pops -> rx_count=4, overrun=1. Pops return 0x01..0x04, then rx_valid=0. Pulse clr_err -> overrun=0.
4. Send 0x55 with the stop bit forced to 0 -> frame_err=1, rx_count unchanged. Release the line high, send 0x66 -> received.
5. With the FIFO full (4 bytes), assert rd_strb in the exact push cycle of a 5th byte 0x77 -> count stays 4, overrun=0. Pops yield bytes 2,3,4 then 0x77. rd_strb while empty -> rx_count stays 0.
6. UART_RX_PARITY_EN defined: send 0x03 with parity=0 -> pushed. Send 0x03 with parity=1 -> parity_err=1, not pushed. Assert resetn=0 mid-byte -> all outputs return to reset values and the next byte is received cleanly.
